// File: rtl/fpu_mul_pkg.sv
// Shared constants and width helpers for the FPU multiply path.
// The stage count is also used by the FPU control to track multiplier latency.
package fpu_mul_pkg;

    localparam int KMUL_STAGES = 3;

    function automatic int half_w(input int width);
        return width / 2;
    endfunction

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/karatsuba_mul_pipe_if.sv
// Streaming operand/result bundle for the Karatsuba multiplier.
// The master drives operands and consumes products; the slave is the multiplier.
interface karatsuba_mul_pipe_if #(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
) ();
    import fpu_mul_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_a;
    logic [WIDTH-1:0]           in_b;
    logic [TAG_W-1:0]           in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [prod_w(WIDTH)-1:0]   out_p;
    logic [TAG_W-1:0]           out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );

endinterface

// File: rtl/karatsuba_stage_ctl.sv
// Valid/advance chain for a linear stall pipeline; a stage advances when it is
// empty or the stage after it advances. Shared with the adder pipeline.
module karatsuba_stage_ctl #(
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [STAGES-1:0] adv
);
    if (STAGES < 2) begin : g_stage_check
        $error("karatsuba_stage_ctl: STAGES must be >= 2");
    end

    logic [STAGES-1:0] valid;
    logic              chain;

    // NOTE: blocking assignments are correct here; chain carries the ripple
    // from the output stage back toward the input within one evaluation.
    always_comb begin
        adv   = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = chain || !valid[i];
            adv[i] = chain;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) valid[i] <= (i == 0) ? in_valid : valid[(i == 0) ? 0 : i - 1];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid[STAGES-1];

endmodule

// File: rtl/karatsuba_mul_pipe.sv
// Pipelined unsigned Karatsuba multiplier: split, three half-width products,
// registered recombine; valid/ready streaming with a tag carried alongside.
module karatsuba_mul_pipe
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    karatsuba_mul_pipe_if.slave bus
);
    localparam int H  = half_w(WIDTH);
    localparam int PW = prod_w(WIDTH);

    if ((WIDTH % 2) != 0 || WIDTH < 8) begin : g_width_check
        $error("karatsuba_mul_pipe: WIDTH must be even and >= 8");
    end

    logic [KMUL_STAGES-1:0] adv;

    karatsuba_stage_ctl #(.STAGES(KMUL_STAGES)) u_ctl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .adv       (adv)
    );

    logic [H-1:0]     a0_s1, a1_s1, b0_s1, b1_s1;
    logic [H:0]       sa_s1, sb_s1;
    logic [TAG_W-1:0] tag_s1;

    // NOTE: payload registers carry no reset; the valid bits alone decide
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (adv[0]) begin
            a0_s1  <= bus.in_a[H-1:0];
            a1_s1  <= bus.in_a[WIDTH-1:H];
            b0_s1  <= bus.in_b[H-1:0];
            b1_s1  <= bus.in_b[WIDTH-1:H];
            sa_s1  <= {1'b0, bus.in_a[H-1:0]} + {1'b0, bus.in_a[WIDTH-1:H]};
            sb_s1  <= {1'b0, bus.in_b[H-1:0]} + {1'b0, bus.in_b[WIDTH-1:H]};
            tag_s1 <= bus.in_tag;
        end
    end

    logic [2*H-1:0]   z0_s2, z2_s2;
    logic [2*H+1:0]   z1_s2;
    logic [TAG_W-1:0] tag_s2;

    // Operands are zero-extended so each product is formed at its full width.
    always_ff @(posedge clk) begin
        if (adv[1]) begin
            z0_s2  <= {{H{1'b0}}, a0_s1} * {{H{1'b0}}, b0_s1};
            z2_s2  <= {{H{1'b0}}, a1_s1} * {{H{1'b0}}, b1_s1};
            z1_s2  <= {{(H+1){1'b0}}, sa_s1} * {{(H+1){1'b0}}, sb_s1};
            tag_s2 <= tag_s1;
        end
    end

    logic [2*H+1:0]   mid;
    logic [PW+1:0]    sum;
    logic [1:0]       sum_unused;
    logic [PW-1:0]    p_s3;
    logic [TAG_W-1:0] tag_s3;

    // mid = a0*b1 + a1*b0, never negative; the top two sum bits are always zero.
    assign mid = z1_s2 - {2'b00, z2_s2} - {2'b00, z0_s2};
    assign sum = {2'b00, z2_s2, {WIDTH{1'b0}}}
               + {{H{1'b0}}, mid, {H{1'b0}}}
               + {{(WIDTH+2){1'b0}}, z0_s2};
    assign sum_unused = sum[PW+1:PW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_s3   <= '0;
            tag_s3 <= '0;
        end else if (adv[2]) begin
            p_s3   <= sum[PW-1:0];
            tag_s3 <= tag_s2;
        end
    end

    assign bus.out_p   = p_s3;
    assign bus.out_tag = tag_s3;

endmodule

// File: tb/tb_karatsuba_mul_pipe.sv
// Directed and randomised checks of karatsuba_mul_pipe at WIDTH 8, 24 and 32:
// latency, exact products, streaming, backpressure, stall hold and reset.
module tb_karatsuba_mul_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    karatsuba_mul_pipe_if #(.WIDTH(8),  .TAG_W(4)) if8  ();
    karatsuba_mul_pipe_if #(.WIDTH(32), .TAG_W(4)) if32 ();
    karatsuba_mul_pipe_if #(.WIDTH(24), .TAG_W(4)) if24 ();

    karatsuba_mul_pipe #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    karatsuba_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    karatsuba_mul_pipe #(.WIDTH(24), .TAG_W(4)) dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));

    // While the 24-bit output is stalled, it must not change across an edge.
    logic        stall_q = 1'b0;
    logic [47:0] held_p;
    logic [3:0]  held_tag;

    always @(negedge clk) begin
        if (stall_q) begin
            checks++;
            if (if24.out_valid !== 1'b1 || if24.out_p !== held_p || if24.out_tag !== held_tag) begin
                failures++;
                $display("FAIL stall_hold got v=%b p=%h t=%h want v=1 p=%h t=%h",
                         if24.out_valid, if24.out_p, if24.out_tag, held_p, held_tag);
            end
        end
        stall_q  = (rst_n === 1'b1) && (if24.out_valid === 1'b1) && (if24.out_ready === 1'b0);
        held_p   = if24.out_p;
        held_tag = if24.out_tag;
    end

    task automatic test_reset();
        if8.in_valid  = 1'b0; if8.out_ready  = 1'b1; if8.in_a  = '0; if8.in_b  = '0; if8.in_tag  = '0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.in_a = '0; if32.in_b = '0; if32.in_tag = '0;
        if24.in_valid = 1'b0; if24.out_ready = 1'b1; if24.in_a = '0; if24.in_b = '0; if24.in_tag = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if24.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", if24.out_valid); end
        checks++;
        if (if24.out_p !== 48'd0) begin failures++; $display("FAIL reset_out_p got=%h want=0", if24.out_p); end
        checks++;
        if (if24.out_tag !== 4'd0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", if24.out_tag); end
        checks++;
        if (if24.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", if24.in_ready); end
        checks++;
        if (if8.out_valid !== 1'b0 || if8.out_p !== 16'd0 || if8.in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_w8 got v=%b p=%h r=%b want 0 0 1", if8.out_valid, if8.out_p, if8.in_ready); end
        checks++;
        if (if32.out_valid !== 1'b0 || if32.out_p !== 64'd0 || if32.in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_w32 got v=%b p=%h r=%b want 0 0 1", if32.out_valid, if32.out_p, if32.in_ready); end
        @(posedge clk); #1;
    endtask

    // A pair accepted on an edge is registered through S1, S2, S3 on that
    // edge and the next two, so out_valid rises two edges after the accept.
    task automatic test_carry();
        logic [7:0]  a_tab [2] = '{8'hFF, 8'h0F};
        logic [7:0]  b_tab [2] = '{8'hFF, 8'hF0};
        logic [15:0] p_tab [2] = '{16'hFE01, 16'h0E10};
        logic [3:0]  t_tab [2] = '{4'h3, 4'hC};
        int lat;
        for (int i = 0; i < 2; i++) begin
            if8.in_a = a_tab[i]; if8.in_b = b_tab[i]; if8.in_tag = t_tab[i];
            if8.in_valid = 1'b1; if8.out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (if8.in_ready !== 1'b1) begin failures++; $display("FAIL carry_in_ready[%0d] got=%b want=1", i, if8.in_ready); end
            @(posedge clk); #1;
            if8.in_valid = 1'b0;
            lat = 0;
            while (lat < 8 && if8.out_valid !== 1'b1) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat != 2) begin failures++; $display("FAIL carry_latency[%0d] got=%0d want=2", i, lat); end
            checks++;
            if (if8.out_p !== p_tab[i]) begin failures++; $display("FAIL carry_p[%0d] got=%h want=%h", i, if8.out_p, p_tab[i]); end
            checks++;
            if (if8.out_tag !== t_tab[i]) begin failures++; $display("FAIL carry_tag[%0d] got=%h want=%h", i, if8.out_tag, t_tab[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide();
        logic [31:0] a_tab [2] = '{32'hFFFFFFFF, 32'h12345678};
        logic [31:0] b_tab [2] = '{32'hFFFFFFFF, 32'h9ABCDEF0};
        logic [63:0] p_tab [2] = '{64'hFFFFFFFE00000001, 64'h0B00EA4E242D2080};
        int lat;
        for (int i = 0; i < 2; i++) begin
            if32.in_a = a_tab[i]; if32.in_b = b_tab[i]; if32.in_tag = 4'(i + 6);
            if32.in_valid = 1'b1; if32.out_ready = 1'b1;
            @(posedge clk); #1;
            if32.in_valid = 1'b0;
            lat = 0;
            while (lat < 8 && if32.out_valid !== 1'b1) begin @(posedge clk); #1; lat++; end
            checks++;
            if (lat != 2) begin failures++; $display("FAIL wide_latency[%0d] got=%0d want=2", i, lat); end
            checks++;
            if (if32.out_p !== p_tab[i]) begin failures++; $display("FAIL wide_p[%0d] got=%h want=%h", i, if32.out_p, p_tab[i]); end
            checks++;
            if (if32.out_tag !== 4'(i + 6)) begin failures++; $display("FAIL wide_tag[%0d] got=%h want=%h", i, if32.out_tag, 4'(i + 6)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_streaming();
        logic [51:0] exp_q [$];
        logic [51:0] e;
        for (int k = 0; k < 1003; k++) begin
            if (k < 1000) begin
                if24.in_a = 24'($urandom); if24.in_b = 24'($urandom);
                if24.in_tag = 4'(k); if24.in_valid = 1'b1;
            end else begin
                if24.in_valid = 1'b0;
            end
            if24.out_ready = 1'b1;
            @(negedge clk);
            if (k < 1000) begin
                checks++;
                if (if24.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got=%b want=1", k, if24.in_ready); end
            end
            checks++;
            if (if24.out_valid !== (k >= 3)) begin failures++; $display("FAIL stream_out_valid[%0d] got=%b want=%b", k, if24.out_valid, (k >= 3)); end
            if (if24.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stream_extra[%0d] got p=%h want none", k, if24.out_p);
                end else begin
                    e = exp_q.pop_front();
                    if ({if24.out_tag, if24.out_p} !== e) begin
                        failures++; $display("FAIL stream_data[%0d] got=%h want=%h", k, {if24.out_tag, if24.out_p}, e);
                    end
                end
            end
            if (if24.in_valid && if24.in_ready)
                exp_q.push_back({if24.in_tag, {24'd0, if24.in_a} * {24'd0, if24.in_b}});
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stream_lost got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [23:0] a_tab [5] = '{24'h000003, 24'hFFFFFF, 24'h001000, 24'h800000, 24'h123456};
        logic [23:0] b_tab [5] = '{24'h000005, 24'hFFFFFF, 24'h001000, 24'h800000, 24'h000010};
        logic [47:0] p_tab [5] = '{48'h00000000000F, 48'hFFFFFE000001, 48'h000001000000,
                                   48'h400000000000, 48'h000001234560};
        int nin  = 0;
        int nout = 0;
        int cyc  = 0;
        if24.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if24.in_valid = (nin < 5);
            if (nin < 5) begin if24.in_a = a_tab[nin]; if24.in_b = b_tab[nin]; if24.in_tag = 4'(nin + 8); end
            @(negedge clk);
            if (if24.in_valid && if24.in_ready) nin++;
            @(posedge clk); #1;
        end
        checks++;
        if (nin != 3) begin failures++; $display("FAIL bp_accepted got=%0d want=3", nin); end
        checks++;
        if (if24.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", if24.in_ready); end
        checks++;
        if (if24.out_valid !== 1'b1 || if24.out_p !== p_tab[0] || if24.out_tag !== 4'h8) begin
            failures++; $display("FAIL bp_head got v=%b p=%h t=%h want v=1 p=%h t=8", if24.out_valid, if24.out_p, if24.out_tag, p_tab[0]);
        end
        if24.out_ready = 1'b1;
        while (nout < 5 && cyc < 20) begin
            if24.in_valid = (nin < 5);
            if (nin < 5) begin if24.in_a = a_tab[nin]; if24.in_b = b_tab[nin]; if24.in_tag = 4'(nin + 8); end
            @(negedge clk);
            if (if24.out_valid === 1'b1) begin
                checks++;
                if (if24.out_p !== p_tab[nout] || if24.out_tag !== 4'(nout + 8)) begin
                    failures++; $display("FAIL bp_data[%0d] got p=%h t=%h want p=%h t=%h",
                                         nout, if24.out_p, if24.out_tag, p_tab[nout], 4'(nout + 8));
                end
                nout++;
            end
            if (if24.in_valid && if24.in_ready) nin++;
            @(posedge clk); #1;
            cyc++;
        end
        if24.in_valid = 1'b0;
        checks++;
        if (nout != 5 || nin != 5) begin failures++; $display("FAIL bp_count got out=%0d in=%0d want 5 5", nout, nin); end
        @(negedge clk);
        checks++;
        if (if24.out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate got v=%b want=0", if24.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_stalls();
        logic [51:0] exp_q [$];
        logic [51:0] e;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        bit pending = 1'b0;
        while (recv < 10000 && cyc < 60000) begin
            if (!pending) begin
                if (sent < 10000 && $urandom_range(0, 1) == 1) begin
                    if24.in_a = 24'($urandom); if24.in_b = 24'($urandom);
                    if24.in_tag = 4'(sent); if24.in_valid = 1'b1; pending = 1'b1;
                end else begin
                    if24.in_valid = 1'b0;
                end
            end
            if24.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (if24.out_valid && if24.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_extra[%0d] got p=%h want none", recv, if24.out_p);
                end else begin
                    e = exp_q.pop_front();
                    if ({if24.out_tag, if24.out_p} !== e) begin
                        failures++; $display("FAIL rand_data[%0d] got=%h want=%h", recv, {if24.out_tag, if24.out_p}, e);
                    end
                end
                recv++;
            end
            if (if24.in_valid && if24.in_ready) begin
                exp_q.push_back({if24.in_tag, {24'd0, if24.in_a} * {24'd0, if24.in_b}});
                sent++;
                pending = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if24.in_valid = 1'b0; if24.out_ready = 1'b1;
        checks++;
        if (recv != 10000) begin failures++; $display("FAIL rand_timeout got=%0d want=10000", recv); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        int lat;
        if24.out_ready = 1'b0;
        if24.in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if24.in_a = 24'(c + 100); if24.in_b = 24'd7; if24.in_tag = 4'(c);
            @(posedge clk); #1;
        end
        checks++;
        if (if24.out_valid !== 1'b1 || if24.in_ready !== 1'b0) begin
            failures++; $display("FAIL rm_full got v=%b r=%b want v=1 r=0", if24.out_valid, if24.in_ready);
        end
        if24.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (if24.out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b want=0", if24.out_valid); end
        checks++;
        if (if24.out_p !== 48'd0 || if24.out_tag !== 4'd0) begin failures++; $display("FAIL rm_out_p got p=%h t=%h want 0 0", if24.out_p, if24.out_tag); end
        checks++;
        if (if24.in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%b want=1", if24.in_ready); end
        if24.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if24.out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rm_stale got=1 want=0"); end
        if24.in_a = 24'd3; if24.in_b = 24'd5; if24.in_tag = 4'h5; if24.in_valid = 1'b1;
        @(posedge clk); #1;
        if24.in_valid = 1'b0;
        lat = 0;
        while (lat < 8 && if24.out_valid !== 1'b1) begin @(posedge clk); #1; lat++; end
        checks++;
        if (if24.out_valid !== 1'b1 || if24.out_p !== 48'd15 || if24.out_tag !== 4'h5) begin
            failures++; $display("FAIL rm_new got v=%b p=%h t=%h want v=1 p=f t=5", if24.out_valid, if24.out_p, if24.out_tag);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_carry();
        test_wide();
        test_streaming();
        test_backpressure();
        test_random_stalls();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
